// File: rtl/param_reg_file.sv
// Two-read/one-write register file with SP, PC and RA special registers.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module param_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int WIDE_W = 16,
  parameter logic [WIDE_W-1:0] SP_INIT = 16'hFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [1:0]        i_sp_op,
  input  logic [1:0]        i_pc_op,
  input  logic [WIDE_W-1:0] i_wide_data,
  output logic [WIDE_W-1:0] o_sp,
  output logic [WIDE_W-1:0] o_pc,
  output logic [WIDE_W-1:0] o_ra,
  output logic              o_wr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_next1;
  logic [DATA_W-1:0] rd_next2;
  logic              wr_hit;

  assign wr_hit = i_wr_en && (i_wr_addr != '0);

  always_comb begin
    rd_next1 = regs[i_rd_addr1];
    rd_next2 = regs[i_rd_addr2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_hit && (i_wr_addr == i_rd_addr1))
      rd_next1 = i_wr_data;
    if (wr_hit && (i_wr_addr == i_rd_addr2))
      rd_next2 = i_wr_data;
`endif
    // Register 0 is hardwired to zero, bypass included.
    if (i_rd_addr1 == '0)
      rd_next1 = '0;
    if (i_rd_addr2 == '0)
      rd_next2 = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      o_rd_data1 <= '0;
      o_rd_data2 <= '0;
      o_rd_valid <= 1'b0;
      o_wr_done  <= 1'b0;
    end else begin
      if (wr_hit)
        regs[i_wr_addr] <= i_wr_data;
      if (i_rd_en) begin
        o_rd_data1 <= rd_next1;
        o_rd_data2 <= rd_next2;
      end
      o_rd_valid <= i_rd_en;
      o_wr_done  <= i_wr_en;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sp <= SP_INIT;
    end else begin
      unique case (i_sp_op)
        2'b01:   o_sp <= o_sp + WIDE_W'(1);
        2'b10:   o_sp <= o_sp - WIDE_W'(1);
        2'b11:   o_sp <= i_wide_data;
        default: o_sp <= o_sp;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc <= '0;
      o_ra <= '0;
    end else begin
      unique case (i_pc_op)
        2'b01: o_pc <= o_pc + WIDE_W'(1);
        2'b10: o_pc <= i_wide_data;
        2'b11: begin
          o_ra <= o_pc + WIDE_W'(1);
          o_pc <= i_wide_data;
        end
        default: o_pc <= o_pc;
      endcase
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: directed scenarios then random traffic.
// Expected behaviour comes from an array/arithmetic reference model.
module tb_param_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [2:0]  rd_addr1, rd_addr2;
  logic [7:0]  rd_data1, rd_data2;
  logic        rd_valid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  sp_op, pc_op;
  logic [15:0] wide_data;
  logic [15:0] sp, pc, ra;
  logic        wr_done;

  param_reg_file dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_en(rd_en), .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
    .o_rd_data1(rd_data1), .o_rd_data2(rd_data2), .o_rd_valid(rd_valid),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_sp_op(sp_op), .i_pc_op(pc_op), .i_wide_data(wide_data),
    .o_sp(sp), .o_pc(pc), .o_ra(ra), .o_wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        done;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [15:0] sp;
    logic [15:0] pc;
    logic [15:0] ra;
  } cyc_t;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d2;
  } rd_t;

  cyc_t cq[$];
  rd_t  rq[$];

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0]  mreg [8];
  logic [7:0]  md1, md2;
  logic [15:0] msp, mpc, mra;
  bit          bypass;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input logic [2:0] a, input bit we,
                                       input logic [2:0] wa,
                                       input logic [7:0] wd);
    if (a == 0) return 8'h00;
    if (bypass && we && wa == a) return wd;
    return mreg[a];
  endfunction

  task automatic drive(input bit r, input bit re, input logic [2:0] a1,
                       input logic [2:0] a2, input bit we,
                       input logic [2:0] wa, input logic [7:0] wd,
                       input logic [1:0] so, input logic [1:0] po,
                       input logic [15:0] wv);
    cyc_t c;
    rd_t  d;
    @(negedge clk);
    rst = r; rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    sp_op = so; pc_op = po; wide_data = wv;
    if (r) begin
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      md1 = 0; md2 = 0; msp = 16'hFFFF; mpc = 0; mra = 0;
      c.valid = 0; c.done = 0;
    end else begin
      if (re) begin
        md1 = mread(a1, we, wa, wd);
        md2 = mread(a2, we, wa, wd);
        d.d1 = md1; d.d2 = md2;
        rq.push_back(d);
      end
      if (we && wa != 0) mreg[wa] = wd;
      case (so)
        2'd1: msp = msp + 16'd1;
        2'd2: msp = msp - 16'd1;
        2'd3: msp = wv;
        default: ;
      endcase
      case (po)
        2'd1: mpc = mpc + 16'd1;
        2'd2: mpc = wv;
        2'd3: begin mra = mpc + 16'd1; mpc = wv; end
        default: ;
      endcase
      c.valid = re; c.done = we;
    end
    c.d1 = md1; c.d2 = md2; c.sp = msp; c.pc = mpc; c.ra = mra;
    cq.push_back(c);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per cycle, read data popped on valid.
  initial begin
    cyc_t c;
    rd_t  d;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(c.valid));
        chk("wr_done", 32'(wr_done), 32'(c.done));
        chk("sp", 32'(sp), 32'(c.sp));
        chk("pc", 32'(pc), 32'(c.pc));
        chk("ra", 32'(ra), 32'(c.ra));
        if (!rd_valid) begin
          chk("hold_d1", 32'(rd_data1), 32'(c.d1));
          chk("hold_d2", 32'(rd_data2), 32'(c.d2));
        end
        if (rd_valid === 1'b1) begin
          if (rq.size() == 0) begin
            chk("unexpected_read", 32'(rd_valid), 32'd0);
          end else begin
            d = rq.pop_front();
            chk("rd_data1", 32'(rd_data1), 32'(d.d1));
            chk("rd_data2", 32'(rd_data2), 32'(d.d2));
          end
        end
      end
    end
  end

  initial begin
`ifdef REG_FILE_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    md1 = 0; md2 = 0; msp = 16'hFFFF; mpc = 0; mra = 0;
    rst = 1; rd_en = 0; rd_addr1 = 0; rd_addr2 = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    sp_op = 0; pc_op = 0; wide_data = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 7, 0, 0, 0, 0, 0, 0);
    idle();
    drive(0, 0, 0, 0, 1, 3, 8'hA5, 0, 0, 0);
    drive(0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h5A, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 8'h11, 0, 0, 0);
    drive(0, 1, 5, 5, 1, 5, 8'h3C, 0, 0, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 16'h0000);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 16'h1234);
    idle();
    drive(0, 0, 0, 0, 1, 2, 8'h77, 0, 0, 0);
    drive(1, 1, 2, 2, 1, 2, 8'h99, 2'd1, 2'd1, 0);
    drive(0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    idle();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
            3'($urandom), 3'($urandom), $urandom_range(0, 1),
            3'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
            16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom));
    end
    idle();
    idle();
    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    chk("cyc_queue_drained", 32'(cq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  DATA_W  8  general-register width in bits.
  ADDR_W  3  register-address width; depth is 2**ADDR_W.
  WIDE_W  16  width of the SP, PC and RA special registers.
  SP_INIT  16'hFFFF  SP value loaded by reset.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  i_clk  in  1  single clock; all state changes on its rising edge.
  i_rst  in  1  reset, synchronous and active-high.
  i_rd_en  in  1  read request for both read ports.
  i_rd_addr1, i_rd_addr2  in  ADDR_W  read addresses.
  o_rd_data1, o_rd_data2  out  DATA_W  registered read data.
  o_rd_valid  out  1  one-cycle pulse: read data valid.
  i_wr_en  in  1  general-register write strobe.
  i_wr_addr  in  ADDR_W  write address.
  i_wr_data  in  DATA_W  write data.
  i_sp_op  in  2  SP operation: 00 hold, 01 increment, 10 decrement, 11 load.
  i_pc_op  in  2  PC operation: 00 hold, 01 increment, 10 load, 11 call (RA<=PC+1, PC<=load value).
  i_wide_data  in  WIDE_W  load value for SP/PC.
  o_sp, o_pc, o_ra  out  WIDE_W  current special-register values.
  o_wr_done  out  1  one-cycle pulse one cycle after an accepted write.

Function
REQ-003 Register 0 SHALL read as zero on every port; writes to address 0 SHALL be discarded, and o_wr_done SHALL still pulse.
REQ-004 Read latency SHALL be exactly one cycle: when i_rd_en is 1 at edge N, o_rd_data1/2 SHALL hold the addressed values and o_rd_valid SHALL be 1 after edge N, for that cycle only.
REQ-005 When i_rd_en is 0, o_rd_data1/2 SHALL hold their last values and o_rd_valid SHALL be 0.
REQ-006 Port 1 SHALL use i_rd_addr1 only and port 2 SHALL use i_rd_addr2 only; the two ports are independent and may use the same address.
REQ-007 Read and write in the same cycle SHALL both be performed; neither has priority over the other.
REQ-008 A write to address A at edge N SHALL be visible to any read issued at edge N+1 or later.
REQ-009 Same-cycle read and write to the same nonzero address: the result is set by the configuration (REQ-016).
REQ-010 SP increment and decrement SHALL wrap modulo 2**WIDE_W: FFFF+1 gives 0000 and 0000-1 gives FFFF.
REQ-011 PC increment SHALL wrap modulo 2**WIDE_W.
REQ-012 PC call SHALL write RA with (old PC + 1) mod 2**WIDE_W and PC with i_wide_data on the same edge; RA SHALL change only on call.
REQ-013 SP, PC and general-register operations in one cycle SHALL all take effect independently on the same edge.

Reset
REQ-014 When i_rst is 1 at a rising edge, the block SHALL set:
  - all general registers to 0;
  - o_rd_data1/2 to 0;
  - o_rd_valid and o_wr_done to 0;
  - PC and RA to 0;
  - SP to SP_INIT.
REQ-015 Reset SHALL override every request in the same cycle; a read or write in progress SHALL be dropped, with no valid or done pulse on the next cycle.

Configuration
REQ-016 With macro REG_FILE_BYPASS_EN defined, a same-cycle read and write to the same nonzero address SHALL return i_wr_data on that read port.
  - Without the macro, that read SHALL return the pre-write value.
  - Address 0 SHALL return 0 in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  - Reset, then read addresses 0 and 7: both data outputs 00, o_rd_valid one pulse one cycle later; o_sp=FFFF, o_pc=0000.
  - Write 8'hA5 to address 3, then read address 3 on both ports: both outputs A5; write 8'h5A to address 0, read it back: 00, and o_wr_done still pulses.
  - Same-cycle write 8'h3C to address 5 while reading address 5 (old value 8'h11): returns 3C with REG_FILE_BYPASS_EN defined, 11 without it.
  - SP=0000 with i_sp_op=10: SP becomes FFFF; then i_sp_op=01: SP becomes 0000.
  - PC=FFFF with i_pc_op=11 and i_wide_data=1234: RA=0000 and PC=1234 after the same edge.
  - Write to address 2 and i_rst asserted together: register 2 reads 00 afterwards, and no o_wr_done pulse occurs.
